// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one 32-bit ALU behind a single result stage
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [WIDTH-1:0] p0_rs1,
  input  logic [WIDTH-1:0] p0_rs2,
  input  logic [3:0]       p0_sel,
  output logic             p0_resp_valid,
  input  logic             p0_resp_ready,
  output logic [WIDTH-1:0] p0_result,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [WIDTH-1:0] p1_rs1,
  input  logic [WIDTH-1:0] p1_rs2,
  input  logic [3:0]       p1_sel,
  output logic             p1_resp_valid,
  input  logic             p1_resp_ready,
  output logic [WIDTH-1:0] p1_result
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  // Output stage and arbitration pointer
  logic             s_valid_q, s_valid_d;
  logic             s_owner_q, s_owner_d;
  logic [WIDTH-1:0] s_result_q, s_result_d;
  logic             last_grant_q, last_grant_d;

  logic             stage_free;
  logic             grant0, grant1;
  logic             fire;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [3:0]       alu_sel;

  // Stage can take a new op when empty or when its owner is draining it this cycle
  always_comb begin
    stage_free = !s_valid_q || (s_owner_q ? p1_resp_ready : p0_resp_ready);
  end

  // Grant from valids only; on a tie the pointer (or fixed priority) decides
  always_comb begin
    grant0   = p0_valid && (!p1_valid || FIXED_PRIO || last_grant_q);
    grant1   = p1_valid && (!p0_valid || (!FIXED_PRIO && !last_grant_q));
    p0_ready = grant0 && stage_free;
    p1_ready = grant1 && stage_free;
    fire     = p0_ready || p1_ready;
  end

  // Shared ALU operand mux: the granted port drives it
  always_comb begin
    alu_a   = grant1 ? p1_rs1 : p0_rs1;
    alu_b   = grant1 ? p1_rs2 : p0_rs2;
    alu_sel = grant1 ? p1_sel : p0_sel;
  end

  // Combinational ALU; shift amounts use all of rs2, so >= WIDTH clears or sign-fills
  always_comb begin
    alu_y = '0;
    case (alu_sel)
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_SLL:  alu_y = alu_a << alu_b;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
      OP_XOR:  alu_y = alu_a ^ alu_b;
      OP_SRL:  alu_y = alu_a >> alu_b;
      OP_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b);
      OP_OR:   alu_y = alu_a | alu_b;
      OP_AND:  alu_y = alu_a & alu_b;
      OP_ADD:  alu_y = alu_a + alu_b;
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // Next state: capture on fire, otherwise retire a consumed result
  always_comb begin
    s_valid_d    = s_valid_q;
    s_owner_d    = s_owner_q;
    s_result_d   = s_result_q;
    last_grant_d = last_grant_q;
    if (fire) begin
      s_valid_d    = 1'b1;
      s_owner_d    = grant1;
      s_result_d   = alu_y;
      last_grant_d = grant1;
    end else if (stage_free) begin
      s_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight result and re-arms port 0 for the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid_q    <= 1'b0;
      s_owner_q    <= 1'b0;
      s_result_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      s_valid_q    <= s_valid_d;
      s_owner_q    <= s_owner_d;
      s_result_q   <= s_result_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Response side: only the owner sees valid, both see the held data
  always_comb begin
    p0_resp_valid = s_valid_q && !s_owner_q;
    p1_resp_valid = s_valid_q && s_owner_q;
    p0_result     = s_result_q;
    p1_result     = s_result_q;
  end

endmodule
